ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Two-master arbiter/sequencer for the single-port 8 KB RAM (ram1port8k, registered q, 1-cycle read latency).
//  Port m0 is the picorv32 memory-bus request, qualified by the RAM address decode.
//  Port m1 is a secondary bus master (DMA / debug loader).
//  Serialises accesses round-robin, drives the RAM pins and returns per-master ready/rdata in picorv32 valid/ready style.
// PARAMETERS
//  ADDR_W       11  RAM word-address width (2048 x 32-bit words)
//  DATA_W       32  data width; byte enables are DATA_W/8 bits
//  WAIT_STATES  0   extra cycles the RAM signals are held in ACCESS (0..15), for slower memories
// PORTS
//  sys_clk     in   1        single clock; all logic on rising edge
//  sys_resetn  in   1        synchronous, active-low reset
//  m0_valid    in   1        master 0 request; held until m0_ready
//  m0_addr     in   ADDR_W   master 0 word address
//  m0_wdata    in   DATA_W   master 0 write data
//  m0_wstrb    in   4        master 0 byte strobes; 0 = read, non-zero = write
//  m0_ready    out  1        1-cycle completion pulse to master 0
//  m0_rdata    out  DATA_W   read data; valid only while m0_ready=1
//  m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata   same as m0_* for master 1
//  ram_address out  ADDR_W   RAM address
//  ram_byteena out  4        RAM byte enables (= latched wstrb on writes, 4'b1111 on reads)
//  ram_data    out  DATA_W   RAM write data
//  ram_rden    out  1        RAM read enable
//  ram_wren    out  1        RAM write enable
//  ram_q       in   DATA_W   RAM read data, valid the cycle after the last ram_rden cycle
//  grant       out  2        one-hot current owner ({m1,m0}); 2'b00 in IDLE
// BEHAVIOUR
//  Reset (sys_resetn=0 at a clock edge):
//   - state=IDLE, last_grant=m1 (so m0 wins the first tie), wait counter=0.
//   - Outputs while in reset/IDLE: m*_ready=0, ram_rden=0, ram_wren=0, grant=0, m*_rdata=0.
//  FSM:
//   - IDLE:
//     - No valid: stay in IDLE.
//     - Exactly one valid: grant that master.
//     - Both valid: grant the master NOT equal to last_grant.
//     - On grant: latch addr/wdata/wstrb/owner into request registers, update last_grant, go to ACCESS.
//   - ACCESS:
//     - RAM pins driven from the latched request: ram_wren=|wstrb, ram_rden=~|wstrb.
//     - Counter runs 0..WAIT_STATES; at WAIT_STATES go to DONE (ACCESS lasts WAIT_STATES+1 cycles).
//   - DONE:
//     - RAM enables 0; owner's m*_ready=1 for exactly one cycle.
//     - Owner's m*_rdata=ram_q on reads, 0 on writes; the other port's ready/rdata stay 0.
//     - Always returns to IDLE.
//  Latency:
//   - valid first seen high at edge T -> ACCESS from T+1 -> ready high during cycle T+2+WAIT_STATES.
//   - Throughput: one access per 3+WAIT_STATES cycles.
//  Request changes:
//   - Master inputs changing after grant are ignored (latched copy used).
//   - A valid still high in IDLE after DONE is treated as a new request.
//  Fairness: with both masters continuously requesting, grants strictly alternate; neither master waits more than one foreign access.
//  Writes: only strobed bytes change; wstrb=0 with valid is a read.
//  Reset mid-operation:
//   - Returns to IDLE on the next edge; no ready is issued for the aborted access.
//   - A write whose ACCESS edge already occurred may have been committed.
//   - Requests still held after reset release are re-arbitrated and served once.
//  No combinational path from m*_valid to m*_ready; grant/ready/RAM enables are decoded from registered state only.
// TESTING
//  1. RAM[0x005]=0xDEADBEEF, m0 read 0x005 at T -> ram_rden=1 at T+1, m0_ready=1 with m0_rdata=0xDEADBEEF at T+2, m1_ready=0.
//  2. RAM[0x7FF]=0xAAAAAAAA, m1 write 0x12345678 wstrb=0011 -> m1_ready at T+2; m0 read 0x7FF returns 0xAAAA5678.
//  3. m0_valid, m1_valid held high from reset release -> grant sequence 01,10,01,10; each master's ready every 6 cycles.
//  4. WAIT_STATES=2, m0 read -> ram_rden high for 3 cycles, m0_ready at T+4 with correct data.
//  5. sys_resetn=0 during ACCESS of an m1 read -> next cycle IDLE, enables 0, no m1_ready; after release the held request completes once.
//  6. m0 write to 0x010 with wstrb=0000 -> treated as a read: ram_wren never asserted, RAM contents unchanged, m0_rdata=RAM[0x010].

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the two RAM masters, the arbiter and the single-port RAM.
// The arbiter takes the slave view; the master view drives requests and the RAM read data.
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              m0_valid;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [STRB_W-1:0] m0_wstrb;
    logic              m0_ready;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_valid;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic [STRB_W-1:0] m1_wstrb;
    logic              m1_ready;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] ram_address;
    logic [STRB_W-1:0] ram_byteena;
    logic [DATA_W-1:0] ram_data;
    logic              ram_rden;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    logic [1:0]        grant;

    modport slave (
        input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
        input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
        input  ram_q,
        output m0_ready, m0_rdata, m1_ready, m1_rdata,
        output ram_address, ram_byteena, ram_data, ram_rden, ram_wren,
        output grant
    );

    modport master (
        output m0_valid, m0_addr, m0_wdata, m0_wstrb,
        output m1_valid, m1_addr, m1_wdata, m1_wstrb,
        output ram_q,
        input  m0_ready, m0_rdata, m1_ready, m1_rdata,
        input  ram_address, ram_byteena, ram_data, ram_rden, ram_wren,
        input  grant
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin two-master sequencer for a single-port RAM with registered read data.
// Each access is IDLE -> ACCESS (WAIT_STATES+1 cycles) -> DONE, one completion pulse per grant.
module ram_port_arbiter #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input logic               sys_clk,
    input logic               sys_resetn,
    ram_port_arbiter_if.slave bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam logic [3:0] WS_LAST = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_m1_q, last_m1_d;
    logic              owner_m1_q, owner_m1_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              pick_m1;

    always_comb begin
        state_d    = state_q;
        last_m1_d  = last_m1_q;
        owner_m1_d = owner_m1_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        // On a tie the master that did not win last time is served.
        pick_m1    = bus.m1_valid && (!bus.m0_valid || !last_m1_q);

        unique case (state_q)
            S_IDLE: begin
                if (bus.m0_valid || bus.m1_valid) begin
                    owner_m1_d = pick_m1;
                    last_m1_d  = pick_m1;
                    wait_cnt_d = '0;
                    addr_d     = pick_m1 ? bus.m1_addr  : bus.m0_addr;
                    wdata_d    = pick_m1 ? bus.m1_wdata : bus.m0_wdata;
                    wstrb_d    = pick_m1 ? bus.m1_wstrb : bus.m0_wstrb;
                    state_d    = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (wait_cnt_q == WS_LAST) begin
                    wait_cnt_d = '0;
                    state_d    = S_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_resetn) begin
            state_q    <= S_IDLE;
            last_m1_q  <= 1'b1;
            owner_m1_q <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_m1_q  <= last_m1_d;
            owner_m1_q <= owner_m1_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // The latched request is only consumed behind a valid state, so it needs no reset.
    always_ff @(posedge sys_clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        wstrb_q <= wstrb_d;
    end

    logic in_access, in_done, is_write, m0_rdy, m1_rdy;

    assign in_access = (state_q == S_ACCESS);
    assign in_done   = (state_q == S_DONE);
    assign is_write  = |wstrb_q;
    assign m0_rdy    = in_done && !owner_m1_q;
    assign m1_rdy    = in_done && owner_m1_q;

    assign bus.ram_address = addr_q;
    assign bus.ram_data    = wdata_q;
    assign bus.ram_byteena = is_write ? wstrb_q : '1;
    assign bus.ram_rden    = in_access && !is_write;
    assign bus.ram_wren    = in_access && is_write;
    assign bus.grant       = (in_access || in_done) ? {owner_m1_q, !owner_m1_q} : 2'b00;

    assign bus.m0_ready = m0_rdy;
    assign bus.m1_ready = m1_rdy;
    assign bus.m0_rdata = (m0_rdy && !is_write) ? bus.ram_q : '0;
    assign bus.m1_rdata = (m1_rdy && !is_write) ? bus.ram_q : '0;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus randomized two-master traffic,
// checked by a per-master expected-response scoreboard fed from a word-level memory model.
module tb_ram_port_arbiter;
    localparam int AW = 11;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0();
    ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus2();

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(0)) u_dut0 (
        .sys_clk(clk), .sys_resetn(resetn), .bus(bus0));
    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(2)) u_dut2 (
        .sys_clk(clk), .sys_resetn(resetn), .bus(bus2));

    logic [31:0] mem0 [0:2047];
    logic [31:0] mem2 [0:2047];
    logic [31:0] ref_mem [0:2047];
    logic [31:0] q0, q2;
    logic        bd_we = 1'b0;
    logic [10:0] bd_addr = '0;
    logic [31:0] bd_data = '0;

    assign bus0.ram_q = q0;
    assign bus2.ram_q = q2;

    // RAM models: registered q, byte-enabled writes, plus a backdoor preload port.
    always @(posedge clk) begin
        if (bd_we) begin
            mem0[bd_addr] <= bd_data;
            mem2[bd_addr] <= bd_data;
        end
        if (bus0.ram_wren)
            for (int b = 0; b < 4; b++)
                if (bus0.ram_byteena[b]) mem0[bus0.ram_address][8*b +: 8] <= bus0.ram_data[8*b +: 8];
        if (bus0.ram_rden) q0 <= mem0[bus0.ram_address];
        if (bus2.ram_wren)
            for (int b = 0; b < 4; b++)
                if (bus2.ram_byteena[b]) mem2[bus2.ram_address][8*b +: 8] <= bus2.ram_data[8*b +: 8];
        if (bus2.ram_rden) q2 <= mem2[bus2.ram_address];
    end

    int n_chk = 0;
    int n_fail = 0;
    int wren_cnt = 0;
    logic [31:0] exp0[$];
    logic [31:0] exp1[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Monitor: pops the owner's expected response on every ready pulse.
    always @(negedge clk) begin
        if (bus0.ram_wren) wren_cnt++;
        if (bus0.m0_ready) begin
            if (exp0.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL m0_unexpected_ready: got ready with rdata 0x%0h, expected no ready", bus0.m0_rdata);
            end else chk("m0_rdata", 64'(bus0.m0_rdata), 64'(exp0.pop_front()));
            chk("m1_quiet_during_m0", 64'({bus0.m1_ready, bus0.m1_rdata}), 64'd0);
        end
        if (bus0.m1_ready) begin
            if (exp1.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL m1_unexpected_ready: got ready with rdata 0x%0h, expected no ready", bus0.m1_rdata);
            end else chk("m1_rdata", 64'(bus0.m1_rdata), 64'(exp1.pop_front()));
            chk("m0_quiet_during_m1", 64'({bus0.m0_ready, bus0.m0_rdata}), 64'd0);
        end
    end

    task automatic preload(input logic [10:0] a, input logic [31:0] v);
        bd_addr = a; bd_data = v; bd_we = 1'b1;
        ref_mem[a] = v;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic scramble(input int m);
        if (m == 0) begin
            bus0.m0_addr = 11'($urandom); bus0.m0_wdata = $urandom; bus0.m0_wstrb = 4'($urandom);
        end else begin
            bus0.m1_addr = 11'($urandom); bus0.m1_wdata = $urandom; bus0.m1_wstrb = 4'($urandom);
        end
    endtask

    // Issue one request on bus0 (called at a negedge) and wait for its ready pulse.
    task automatic issue(input int m, input logic [10:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] e,
                         output int cyc, output logic r1, output logic w1);
        logic rdy;
        if (m == 0) begin
            exp0.push_back(e);
            bus0.m0_addr = a; bus0.m0_wdata = d; bus0.m0_wstrb = s; bus0.m0_valid = 1'b1;
        end else begin
            exp1.push_back(e);
            bus0.m1_addr = a; bus0.m1_wdata = d; bus0.m1_wstrb = s; bus0.m1_valid = 1'b1;
        end
        cyc = 0; r1 = 1'b0; w1 = 1'b0; rdy = 1'b0;
        while (!rdy && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin r1 = bus0.ram_rden; w1 = bus0.ram_wren; end
            rdy = (m == 0) ? bus0.m0_ready : bus0.m1_ready;
            if (bus0.grant == ((m == 0) ? 2'b01 : 2'b10)) scramble(m);
        end
        if (!rdy) begin
            n_chk++; n_fail++;
            $display("FAIL timeout_m%0d: no ready after %0d cycles, expected within 40", m, cyc);
        end
        if (m == 0) bus0.m0_valid = 1'b0; else bus0.m1_valid = 1'b0;
    endtask

    task automatic issue_model(input int m, input logic [10:0] a, input logic [31:0] d,
                               input logic [3:0] s, output int cyc);
        logic [31:0] e;
        logic r1, w1;
        if (s == 4'd0) e = ref_mem[a];
        else begin
            ref_mem[a] = merge(ref_mem[a], d, s);
            e = '0;
        end
        issue(m, a, d, s, e, cyc, r1, w1);
    endtask

    task automatic driver(input int m);
        int cyc;
        logic [10:0] a;
        logic [3:0] s;
        for (int k = 0; k < 25; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            a = (m == 0) ? 11'($urandom_range(0, 1023)) : 11'($urandom_range(1024, 2047));
            s = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            issue_model(m, a, $urandom, s, cyc);
            chk($sformatf("fair_wait_m%0d", m), 64'(cyc <= 6), 64'd1);
        end
    endtask

    initial begin
        int cyc, w, rd, n0, n1, seen, first;
        logic r1, w1;
        logic [1:0] prev_g;
        logic [1:0] gq[$];
        int r0t[$];
        int r1t[$];

        bus0.m0_valid = 0; bus0.m0_addr = '0; bus0.m0_wdata = '0; bus0.m0_wstrb = '0;
        bus0.m1_valid = 0; bus0.m1_addr = '0; bus0.m1_wdata = '0; bus0.m1_wstrb = '0;
        bus2.m0_valid = 0; bus2.m0_addr = '0; bus2.m0_wdata = '0; bus2.m0_wstrb = '0;
        bus2.m1_valid = 0; bus2.m1_addr = '0; bus2.m1_wdata = '0; bus2.m1_wstrb = '0;

        @(negedge clk);
        for (int i = 0; i < 2048; i++) preload(11'(i), $urandom);

        chk("reset_ctrl_outputs", 64'({bus0.m0_ready, bus0.m1_ready, bus0.ram_rden, bus0.ram_wren, bus0.grant}), 64'd0);
        chk("reset_rdata", 64'({bus0.m0_rdata, bus0.m1_rdata}), 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("idle_after_release", 64'({bus0.m0_ready, bus0.m1_ready, bus0.ram_rden, bus0.grant}), 64'd0);

        // Single read: rden on the first cycle, ready two cycles after issue.
        preload(11'h005, 32'hDEADBEEF);
        issue(0, 11'h005, 32'h0, 4'h0, 32'hDEADBEEF, cyc, r1, w1);
        chk("t1_latency", 64'(cyc), 64'd2);
        chk("t1_rden_wren", 64'({r1, w1}), 64'b10);

        // Partial write from m1, then read back through m0.
        preload(11'h7FF, 32'hAAAAAAAA);
        issue_model(1, 11'h7FF, 32'h12345678, 4'b0011, cyc);
        chk("t2_write_latency", 64'(cyc), 64'd2);
        issue(0, 11'h7FF, 32'h0, 4'h0, 32'hAAAA5678, cyc, r1, w1);

        // wstrb=0 with write data is a read.
        preload(11'h010, 32'h0BADF00D);
        w = wren_cnt;
        issue(0, 11'h010, 32'h55555555, 4'h0, 32'h0BADF00D, cyc, r1, w1);
        chk("t6_rden_wren", 64'({r1, w1}), 64'b10);
        chk("t6_no_wren", 64'(wren_cnt), 64'(w));
        issue(0, 11'h010, 32'h0, 4'h0, 32'h0BADF00D, cyc, r1, w1);

        // Wait-state instance.
        preload(11'h033, 32'h13579BDF);
        bus2.m0_addr = 11'h033; bus2.m0_wstrb = 4'h0; bus2.m0_valid = 1'b1;
        cyc = 0; rd = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (bus2.ram_rden) rd++;
        end while (!bus2.m0_ready && cyc < 40);
        chk("t4_ready_cycle", 64'(cyc), 64'd4);
        chk("t4_rden_cycles", 64'(rd), 64'd3);
        chk("t4_rdata", 64'(bus2.m0_rdata), 64'h13579BDF);
        chk("t4_m1_quiet", 64'({bus2.m1_ready, bus2.m1_rdata}), 64'd0);
        bus2.m0_valid = 1'b0;

        // Reset during an m1 read; the held request is served once after release.
        preload(11'h120, 32'hCAFE0120);
        exp1.push_back(32'hCAFE0120);
        bus0.m1_addr = 11'h120; bus0.m1_wstrb = 4'h0; bus0.m1_valid = 1'b1;
        @(negedge clk);
        chk("t5_in_access", 64'({bus0.ram_rden, bus0.grant}), 64'b110);
        resetn = 1'b0;
        @(negedge clk);
        chk("t5_aborted", 64'({bus0.ram_rden, bus0.ram_wren, bus0.grant, bus0.m1_ready}), 64'd0);
        resetn = 1'b1;
        seen = 0; first = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus0.m1_ready) begin
                seen++;
                if (first == 0) first = i;
                bus0.m1_valid = 1'b0;
            end
        end
        bus0.m1_valid = 1'b0;
        chk("t5_served_once", 64'(seen), 64'd1);
        chk("t5_ready_cycle", 64'(first), 64'd2);

        // Both masters hold valid from reset release: strict alternation, m0 first.
        preload(11'h040, 32'h00000040);
        preload(11'h440, 32'h00000440);
        resetn = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            exp0.push_back(32'h00000040);
            exp1.push_back(32'h00000440);
        end
        bus0.m0_addr = 11'h040; bus0.m0_wstrb = 4'h0; bus0.m0_valid = 1'b1;
        bus0.m1_addr = 11'h440; bus0.m1_wstrb = 4'h0; bus0.m1_valid = 1'b1;
        resetn = 1'b1;
        prev_g = 2'b00; n0 = 0; n1 = 0; cyc = 0;
        while ((n0 < 4 || n1 < 4) && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus0.grant != 2'b00 && bus0.grant != prev_g) gq.push_back(bus0.grant);
            prev_g = bus0.grant;
            if (bus0.m0_ready) begin r0t.push_back(cyc); n0++; if (n0 == 4) bus0.m0_valid = 1'b0; end
            if (bus0.m1_ready) begin r1t.push_back(cyc); n1++; if (n1 == 4) bus0.m1_valid = 1'b0; end
        end
        bus0.m0_valid = 1'b0; bus0.m1_valid = 1'b0;
        if (gq.size() >= 4 && r0t.size() == 4 && r1t.size() == 4) begin
            chk("t3_grant_seq", 64'({gq[0], gq[1], gq[2], gq[3]}), 64'b01100110);
            chk("t3_first_m0", 64'(r0t[0]), 64'd2);
            chk("t3_first_m1", 64'(r1t[0]), 64'd5);
            for (int k = 1; k < 4; k++) begin
                chk("t3_m0_period", 64'(r0t[k] - r0t[k-1]), 64'd6);
                chk("t3_m1_period", 64'(r1t[k] - r1t[k-1]), 64'd6);
            end
        end else begin
            n_chk++; n_fail++;
            $display("FAIL t3_completions: got %0d/%0d readies and %0d grants, expected 4/4 and 4",
                     r0t.size(), r1t.size(), gq.size());
        end
        @(negedge clk);

        // Randomized concurrent traffic, masters confined to disjoint halves.
        fork
            driver(0);
            driver(1);
        join
        repeat (4) @(negedge clk);

        chk("scoreboard_drained", 64'(exp0.size() + exp1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end
endmodule
